// File: rtl/dshot_frame_decoder.sv
// DSHOT receiver: classifies pulse high-times into bits, assembles 16-bit frames, checks CRC.
// Define DSHOT_BIDIR_EN for inverted (bidirectional) DSHOT with inverted CRC.
module dshot_frame_decoder #(
  parameter int CLK_FREQ_HZ = 72_000_000,
  parameter int DSHOT_BAUD  = 600_000
) (
  input  logic        i_sys_clk,
  input  logic        i_rst_n,
  input  logic        i_dshot,
  output logic        o_valid,
  output logic [10:0] o_throttle,
  output logic        o_telem,
  output logic        o_crc_ok,
  output logic        o_err,
  output logic [1:0]  o_err_code,
  output logic        o_busy
);

  localparam int BIT_CLKS = CLK_FREQ_HZ / DSHOT_BAUD;
  localparam int CNT_W    = $clog2(2 * BIT_CLKS + 1);

  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] GLITCH_CLKS = CNT_W'(BIT_CLKS / 8);
  localparam logic [CNT_W-1:0] HALF_CLKS   = CNT_W'(BIT_CLKS / 2);
  localparam logic [CNT_W-1:0] STUCK_CLKS  = CNT_W'(BIT_CLKS);
  localparam logic [CNT_W-1:0] GAP_CLKS    = CNT_W'(2 * BIT_CLKS);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_HIGH     = 3'd1;
  localparam logic [2:0] S_LOW      = 3'd2;
  localparam logic [2:0] S_CHECK    = 3'd3;
  localparam logic [2:0] S_WAIT_LOW = 3'd4;

`ifdef DSHOT_BIDIR_EN
  localparam logic IDLE_LVL = 1'b1;
`else
  localparam logic IDLE_LVL = 1'b0;
`endif

  logic             sync_q1;
  logic             sync_q2;
  logic             line_s;
  logic             line_q;
  logic             rise;
  logic             fall;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       state;
  logic [3:0]       bitcnt;
  logic [15:0]      shreg;
  logic [11:0]      crc_v;
  logic [3:0]       crc_calc;
  logic [3:0]       crc_exp;

  // Synchronizer flops reset to the idle line level so reset release never looks like an edge.
  always_ff @(posedge i_sys_clk) begin
    if (!i_rst_n) begin
      sync_q1 <= IDLE_LVL;
      sync_q2 <= IDLE_LVL;
    end else begin
      sync_q1 <= i_dshot;
      sync_q2 <= sync_q1;
    end
  end

`ifdef DSHOT_BIDIR_EN
  assign line_s = ~sync_q2;
`else
  assign line_s = sync_q2;
`endif

  assign rise = line_s & ~line_q;
  assign fall = ~line_s & line_q;

  always_ff @(posedge i_sys_clk) begin
    if (!i_rst_n) begin
      line_q <= 1'b0;
      cnt    <= '0;
    end else begin
      line_q <= line_s;
      if (rise || fall) begin
        cnt <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + CNT_ONE;
      end
    end
  end

  assign crc_v    = shreg[15:4];
  assign crc_calc = crc_v[3:0] ^ crc_v[7:4] ^ crc_v[11:8];
`ifdef DSHOT_BIDIR_EN
  assign crc_exp  = ~crc_calc;
`else
  assign crc_exp  = crc_calc;
`endif

  assign o_busy = (state == S_HIGH) || (state == S_LOW);

  // A fall during HIGH wins over the stuck-high timeout; a rise during LOW wins over the gap timeout.
  always_ff @(posedge i_sys_clk) begin
    if (!i_rst_n) begin
      state      <= S_IDLE;
      bitcnt     <= 4'd0;
      shreg      <= 16'd0;
      o_valid    <= 1'b0;
      o_throttle <= 11'd0;
      o_telem    <= 1'b0;
      o_crc_ok   <= 1'b0;
      o_err      <= 1'b0;
      o_err_code <= 2'b00;
    end else begin
      o_valid <= 1'b0;
      o_err   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (rise) begin
            state  <= S_HIGH;
            bitcnt <= 4'd0;
          end
        end
        S_HIGH: begin
          if (fall) begin
            if (cnt < GLITCH_CLKS) begin
              o_err      <= 1'b1;
              o_err_code <= 2'b11;
              state      <= S_IDLE;
            end else begin
              shreg <= {shreg[14:0], (cnt >= HALF_CLKS)};
              if (bitcnt == 4'd15) begin
                state <= S_CHECK;
              end else begin
                bitcnt <= bitcnt + 4'd1;
                state  <= S_LOW;
              end
            end
          end else if (cnt > STUCK_CLKS) begin
            o_err      <= 1'b1;
            o_err_code <= 2'b10;
            state      <= S_WAIT_LOW;
          end
        end
        S_LOW: begin
          if (rise) begin
            state <= S_HIGH;
          end else if (cnt > GAP_CLKS) begin
            o_err      <= 1'b1;
            o_err_code <= 2'b01;
            state      <= S_IDLE;
          end
        end
        S_CHECK: begin
          o_valid    <= 1'b1;
          o_throttle <= shreg[15:5];
          o_telem    <= shreg[4];
          o_crc_ok   <= (shreg[3:0] == crc_exp);
          state      <= S_IDLE;
        end
        S_WAIT_LOW: begin
          if (!line_s) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
